// File: rtl/painel_display.sv
// Multiplexed 4-digit 7-segment panel: shows the level, a dash, the irrigation mode and the flow state.
// Define DISP_HEARTBEAT_EN to add a heartbeat decimal point (dp) in the rightmost digit.
module painel_display #(
  parameter int REFRESH_DIV    = 50000,
  parameter int BLINK_DIV      = 25000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rest,
  input  logic Cheio,
  input  logic Medio,
  input  logic Baixo,
  input  logic Vazio,
  input  logic Erro,
  input  logic Alarme,
  input  logic Vs,
  input  logic Bs,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g,
  output logic d1,
  output logic d2,
  output logic d3,
  output logic d4
`ifdef DISP_HEARTBEAT_EN
  ,
  output logic dp
`endif
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  // Segment patterns, bit order {a,b,c,d,e,f,g}, active-high
  localparam logic [6:0] CH_0     = 7'b1111110;
  localparam logic [6:0] CH_1     = 7'b0110000;
  localparam logic [6:0] CH_2     = 7'b1101101;
  localparam logic [6:0] CH_3     = 7'b1111001;
  localparam logic [6:0] CH_E     = 7'b1001111;
  localparam logic [6:0] CH_A     = 7'b1110111;
  localparam logic [6:0] CH_G     = 7'b1011110;
  localparam logic [6:0] CH_L     = 7'b0001110;
  localparam logic [6:0] CH_D     = 7'b0111101;
  localparam logic [6:0] CH_DASH  = 7'b0000001;
  localparam logic [6:0] CH_BLANK = 7'b0000000;

  logic [7:0]    sync1, sync2;
  logic          s_cheio, s_medio, s_baixo, s_vazio, s_erro, s_alarme, s_vs, s_bs;
  logic [PW-1:0] pcnt;
  logic          pcnt_tc;
  logic [1:0]    idx;
  logic          ghost;
  logic [BW-1:0] bcnt;
  logic          bcnt_tc;
  logic          blink_act;
  logic          phase_on;
  logic [6:0]    level_ch, mode_ch, flow_ch;
  logic [6:0]    seg_n;
  logic [3:0]    dig_n;
  logic [6:0]    seg_q;
  logic [3:0]    dig_q;

  always_ff @(posedge clk) begin
    if (rest) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {Cheio, Medio, Baixo, Vazio, Erro, Alarme, Vs, Bs};
      sync2 <= sync1;
    end
  end

  assign {s_cheio, s_medio, s_baixo, s_vazio, s_erro, s_alarme, s_vs, s_bs} = sync2;

  // Scan prescaler; the cycle after each terminal count is the blanking (ghost) cycle
  assign pcnt_tc = (pcnt == PW'(REFRESH_DIV - 1));

  always_ff @(posedge clk) begin
    if (rest) begin
      pcnt  <= '0;
      idx   <= 2'd0;
      ghost <= 1'b0;
    end else begin
      ghost <= pcnt_tc;
      if (pcnt_tc) begin
        pcnt <= '0;
        idx  <= idx + 2'd1;
      end else begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

  assign blink_act = s_erro | s_alarme;
  assign bcnt_tc   = (bcnt == BW'(BLINK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rest || !blink_act) begin
      bcnt     <= '0;
      phase_on <= 1'b1;
    end else if (bcnt_tc) begin
      bcnt     <= '0;
      phase_on <= ~phase_on;
    end else begin
      bcnt <= bcnt + BW'(1);
    end
  end

  always_comb begin
    level_ch = CH_DASH;
    if (s_erro)       level_ch = CH_E;
    else if (s_cheio) level_ch = CH_3;
    else if (s_medio) level_ch = CH_2;
    else if (s_baixo) level_ch = CH_1;
    else if (s_vazio) level_ch = CH_0;

    mode_ch = CH_DASH;
    case ({s_vs, s_bs})
      2'b10:   mode_ch = CH_A;
      2'b01:   mode_ch = CH_G;
      2'b11:   mode_ch = CH_E;
      default: mode_ch = CH_DASH;
    endcase

    flow_ch = (s_vs || s_bs) ? CH_L : CH_D;
  end

  always_comb begin
    seg_n = CH_BLANK;
    dig_n = 4'b0000;
    if (!ghost) begin
      dig_n[idx] = 1'b1;
      case (idx)
        2'd0:    seg_n = phase_on ? level_ch : CH_BLANK;
        2'd1:    seg_n = CH_DASH;
        2'd2:    seg_n = mode_ch;
        default: seg_n = flow_ch;
      endcase
    end
  end

  // Polarity is applied only at the output flops
  always_ff @(posedge clk) begin
    if (rest) begin
      seg_q <= {7{SEG_ACTIVE_LOW}};
      dig_q <= {4{SEG_ACTIVE_LOW}};
    end else begin
      seg_q <= seg_n ^ {7{SEG_ACTIVE_LOW}};
      dig_q <= dig_n ^ {4{SEG_ACTIVE_LOW}};
    end
  end

  assign {a, b, c, d, e, f, g} = seg_q;
  assign {d4, d3, d2, d1}      = dig_q;

`ifdef DISP_HEARTBEAT_EN
  logic [BW-1:0] hcnt;
  logic          hb;
  logic          dp_q;

  always_ff @(posedge clk) begin
    if (rest) begin
      hcnt <= '0;
      hb   <= 1'b0;
      dp_q <= SEG_ACTIVE_LOW;
    end else begin
      if (hcnt == BW'(BLINK_DIV - 1)) begin
        hcnt <= '0;
        hb   <= ~hb;
      end else begin
        hcnt <= hcnt + BW'(1);
      end
      dp_q <= (!ghost && (idx == 2'd3) && hb) ^ SEG_ACTIVE_LOW;
    end
  end

  assign dp = dp_q;
`endif

endmodule

// File: tb/tb_painel_display.sv
// Bench for painel_display: reset, table of status patterns over full scans, blink timing,
// active-low polarity and reset mid-scan.
module tb_painel_display;

  localparam logic [6:0] C0    = 7'b1111110;
  localparam logic [6:0] C1    = 7'b0110000;
  localparam logic [6:0] C2    = 7'b1101101;
  localparam logic [6:0] C3    = 7'b1111001;
  localparam logic [6:0] CE    = 7'b1001111;
  localparam logic [6:0] CA    = 7'b1110111;
  localparam logic [6:0] CG    = 7'b1011110;
  localparam logic [6:0] CL    = 7'b0001110;
  localparam logic [6:0] CD    = 7'b0111101;
  localparam logic [6:0] DASH  = 7'b0000001;
  localparam logic [6:0] BLANK = 7'b0000000;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rest;

  logic cheio, medio, baixo, vazio, erro, alarme, vs, bs;
  logic a, b, c, d, e, f, g, d1, d2, d3, d4;
  logic na, nb, nc, nd, ne, nf, ng, nd1, nd2, nd3, nd4;
`ifdef DISP_HEARTBEAT_EN
  logic dp, ndp;
`endif

  logic [6:0] seg, nseg;
  logic [3:0] dig, ndig;
  assign seg  = {a, b, c, d, e, f, g};
  assign dig  = {d4, d3, d2, d1};
  assign nseg = {na, nb, nc, nd, ne, nf, ng};
  assign ndig = {nd4, nd3, nd2, nd1};

  painel_display #(.REFRESH_DIV(4), .BLINK_DIV(16), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rest(rest),
    .Cheio(cheio), .Medio(medio), .Baixo(baixo), .Vazio(vazio),
    .Erro(erro), .Alarme(alarme), .Vs(vs), .Bs(bs),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4)
`ifdef DISP_HEARTBEAT_EN
    , .dp(dp)
`endif
  );

  painel_display #(.REFRESH_DIV(4), .BLINK_DIV(16), .SEG_ACTIVE_LOW(1'b1)) dut_n (
    .clk(clk), .rest(rest),
    .Cheio(cheio), .Medio(medio), .Baixo(baixo), .Vazio(vazio),
    .Erro(erro), .Alarme(alarme), .Vs(vs), .Bs(bs),
    .a(na), .b(nb), .c(nc), .d(nd), .e(ne), .f(nf), .g(ng),
    .d1(nd1), .d2(nd2), .d3(nd3), .d4(nd4)
`ifdef DISP_HEARTBEAT_EN
    , .dp(ndp)
`endif
  );

  // scoreboard counters
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // input order {Cheio,Medio,Baixo,Vazio,Erro,Alarme,Vs,Bs}
  task automatic set_in(input logic [7:0] v);
    {cheio, medio, baixo, vazio, erro, alarme, vs, bs} = v;
  endtask

  logic [6:0] frame_seg[4];
  int         frame_cnt[4];
  int         frame_ghost, frame_bad_ghost, frame_multi, frame_var;

  task automatic scan(input int cycles);
    for (int i = 0; i < 4; i++) begin
      frame_cnt[i] = 0;
      frame_seg[i] = BLANK;
    end
    frame_ghost = 0; frame_bad_ghost = 0; frame_multi = 0; frame_var = 0;
    repeat (cycles) begin
      step();
      if ($countones(dig) > 1) frame_multi++;
      else if (dig == 4'b0000) begin
        frame_ghost++;
        if (seg != BLANK) frame_bad_ghost++;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (dig[i]) begin
            if (frame_cnt[i] > 0 && seg != frame_seg[i]) frame_var++;
            frame_seg[i] = seg;
            frame_cnt[i]++;
          end
        end
      end
    end
  endtask

  typedef struct {
    logic [7:0] in;
    logic [6:0] s1;
    logic [6:0] s3;
    logic [6:0] s4;
  } vec_t;

  vec_t vecs[10];

  initial begin
    bit found;
    logic [6:0] exp_s;

    vecs[0] = '{8'h00, DASH, DASH, CD};
    vecs[1] = '{8'h82, C3,   CA,   CL};
    vecs[2] = '{8'h40, C2,   DASH, CD};
    vecs[3] = '{8'h21, C1,   CG,   CL};
    vecs[4] = '{8'h13, C0,   CE,   CL};
    vecs[5] = '{8'hF0, C3,   DASH, CD};
    vecs[6] = '{8'h60, C2,   DASH, CD};
    vecs[7] = '{8'h31, C1,   CG,   CL};
    vecs[8] = '{8'h10, C0,   DASH, CD};
    vecs[9] = '{8'h01, DASH, CG,   CL};

    // reset state
    rest = 1'b1;
    set_in(8'h00);
    repeat (3) step();
    check("reset_seg", seg, 7'h00);
    check("reset_dig", dig, 4'h0);
    check("reset_nseg", nseg, 7'h7F);
    check("reset_ndig", ndig, 4'hF);

    rest = 1'b0;
    step();
    check("release_dig", dig, 4'b0001);
    check("release_seg", seg, DASH);

    // table: each pattern held over 64 cycles (four full scans)
    for (int v = 0; v < 10; v++) begin
      set_in(vecs[v].in);
      repeat (8) step();
      scan(64);
      check($sformatf("v%0d_d1_seg", v), frame_seg[0], vecs[v].s1);
      check($sformatf("v%0d_d2_seg", v), frame_seg[1], DASH);
      check($sformatf("v%0d_d3_seg", v), frame_seg[2], vecs[v].s3);
      check($sformatf("v%0d_d4_seg", v), frame_seg[3], vecs[v].s4);
      for (int i = 0; i < 4; i++)
        check($sformatf("v%0d_d%0d_cnt", v, i + 1), frame_cnt[i], 12);
      check($sformatf("v%0d_ghosts", v), frame_ghost, 16);
      check($sformatf("v%0d_ghost_segs", v), frame_bad_ghost, 0);
      check($sformatf("v%0d_onehot", v), frame_multi, 0);
      check($sformatf("v%0d_steady", v), frame_var, 0);
    end

    // blink: Cheio held, then Erro raised; 16-cycle on/off phases start 3 edges later
    set_in(8'h80);
    repeat (8) step();
    set_in(8'h88);
    for (int n = 1; n <= 70; n++) begin
      step();
      if ($countones(dig) > 1) check($sformatf("blink_onehot_%0d", n), dig, 4'b0001);
      else if (n >= 3) begin
        if (dig[0]) begin
          exp_s = (((n - 3) / 16) % 2 == 1) ? BLANK : CE;
          check($sformatf("blink_d1_%0d", n), seg, exp_s);
        end
        if (dig[1]) check($sformatf("blink_d2_%0d", n), seg, DASH);
        if (dig[2]) check($sformatf("blink_d3_%0d", n), seg, DASH);
        if (dig[3]) check($sformatf("blink_d4_%0d", n), seg, CD);
      end
    end

    // active-low instance, Medio in the d1 slot
    set_in(8'h40);
    repeat (8) step();
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      step();
      if (ndig[0] == 1'b0) found = 1'b1;
    end
    check("al_found_d1", found, 1'b1);
    check("al_dig", ndig, 4'b1110);
    check("al_seg", nseg, 7'b0010010);

    // reset while d3 is active with Alarme set
    set_in(8'h04);
    repeat (4) step();
    found = 1'b0;
    for (int n = 0; n < 32 && !found; n++) begin
      step();
      if (dig[2]) found = 1'b1;
    end
    check("mid_found_d3", found, 1'b1);
    rest = 1'b1;
    step();
    check("mid_rst_seg", seg, 7'h00);
    check("mid_rst_dig", dig, 4'h0);
    check("mid_rst_nseg", nseg, 7'h7F);
    check("mid_rst_ndig", ndig, 4'hF);
    step();
    rest = 1'b0;
    step();
    check("mid_rel_dig", dig, 4'b0001);
    check("mid_rel_seg", seg, DASH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
